// File: rtl/evg_sequencer_multibank.sv
// rtl/evg_sequencer_multibank.sv - multi-bank (gap, event) table player with backpressure, repeat and abort
module evg_sequencer_multibank #(
    parameter int SEQUENCE_RAM_CAPACITY = 1024,
    parameter int BANK_COUNT = 4,
    parameter int EVENTCODE_WIDTH = 8,
    parameter int SEQUENCE_GAP_WIDTH = 24,
    parameter int REPEAT_WIDTH = 8,
    parameter logic [EVENTCODE_WIDTH-1:0] END_OF_TABLE_EVENT_CODE = 8'h7F,
    localparam int IW = $clog2(SEQUENCE_RAM_CAPACITY),
    localparam int BW = $clog2(BANK_COUNT),
    localparam int DW = SEQUENCE_GAP_WIDTH + EVENTCODE_WIDTH
) (
    input  logic                       evgTxClk,
    input  logic                       evgTxRst_n,
    input  logic                       wrEnable,
    input  logic [BW+IW-1:0]           wrAddress,
    input  logic [DW-1:0]              wrData,
    input  logic                       armStrobe,
    input  logic [BW-1:0]              armBank,
    input  logic [REPEAT_WIDTH-1:0]    armRepeat,
    input  logic                       armPersistent,
    input  logic                       abortStrobe,
    input  logic                       evgSequenceStart,
    output logic [EVENTCODE_WIDTH-1:0] evgSequenceEventTDATA,
    output logic                       evgSequenceEventTVALID,
    input  logic                       evgSequenceEventTREADY,
    output logic                       sequenceActive,
    output logic [BW-1:0]              activeBank,
    output logic                       armed,
    output logic [REPEAT_WIDTH-1:0]    passesRemaining,
    output logic [7:0]                 startRequestsAccepted,
    output logic [7:0]                 startRequestsIgnored
);
    localparam int GW = SEQUENCE_GAP_WIDTH;
    localparam int EW = EVENTCODE_WIDTH;
    localparam int RW = REPEAT_WIDTH;
    localparam logic [GW:0] CNT_ONE = 1;
    localparam logic [IW:0] IDX_ONE = 1;
    localparam logic [IW-1:0] RD_ONE = 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH_A, S_FETCH_D, S_WAIT, S_EMIT} state_t;

    state_t        state;
    logic [DW-1:0] mem [BANK_COUNT*SEQUENCE_RAM_CAPACITY];
    logic [DW-1:0] rd_q;
    logic [IW:0]   idx;
    logic [IW-1:0] rd_idx;
    logic [GW:0]   gap_cnt;
    logic [BW-1:0] arm_bank_q;
    logic [RW-1:0] arm_repeat_q;
    logic          arm_persist_q;
    logic [GW-1:0] rd_gap;
    logic [EW-1:0] rd_code;
    logic          rd_end, accept, end_pass, start_ok;

    // idx always names the entry after the one in TDATA; rd_q tracks mem[idx]
    assign rd_gap   = rd_q[DW-1:EW];
    assign rd_code  = rd_q[EW-1:0];
    assign rd_end   = idx[IW] || (rd_code == END_OF_TABLE_EVENT_CODE);
    assign accept   = evgSequenceEventTVALID && evgSequenceEventTREADY;
    assign end_pass = rd_end && ((state == S_FETCH_D) || (state == S_EMIT && accept));
    assign start_ok = evgSequenceStart && armed && !abortStrobe && (state == S_IDLE);

    // Address from the post-edge index so gap=0 entries can go out back to back
    always_comb begin
        rd_idx = idx[IW-1:0];
        if (state == S_FETCH_D || (state == S_EMIT && accept))
            rd_idx = idx[IW-1:0] + RD_ONE;
    end

    always_ff @(posedge evgTxClk) begin
        if (wrEnable)
            mem[wrAddress] <= wrData;
        rd_q <= mem[{activeBank, rd_idx}];
    end

    always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
        if (!evgTxRst_n) begin
            state                  <= S_IDLE;
            evgSequenceEventTVALID <= 1'b0;
            evgSequenceEventTDATA  <= '0;
            sequenceActive         <= 1'b0;
            activeBank             <= '0;
            armed                  <= 1'b0;
            passesRemaining        <= '0;
            startRequestsAccepted  <= '0;
            startRequestsIgnored   <= '0;
            idx                    <= '0;
            gap_cnt                <= '0;
            arm_bank_q             <= '0;
            arm_repeat_q           <= '0;
            arm_persist_q          <= 1'b0;
        end else begin
            if (evgSequenceStart && !start_ok && startRequestsIgnored != 8'hFF)
                startRequestsIgnored <= startRequestsIgnored + 8'd1;
            if (abortStrobe) begin
                state                  <= S_IDLE;
                evgSequenceEventTVALID <= 1'b0;
                sequenceActive         <= 1'b0;
                armed                  <= 1'b0;
            end else if (end_pass) begin
                evgSequenceEventTVALID <= 1'b0;
                if (passesRemaining == '0) begin
                    state          <= S_IDLE;
                    sequenceActive <= 1'b0;
                end else begin
                    if (!(&passesRemaining))
                        passesRemaining <= passesRemaining - RW'(1);
                    idx   <= '0;
                    state <= S_FETCH_A;
                end
            end else begin
                case (state)
                    S_IDLE: if (start_ok) begin
                        activeBank            <= arm_bank_q;
                        passesRemaining       <= arm_repeat_q;
                        sequenceActive        <= 1'b1;
                        startRequestsAccepted <= startRequestsAccepted + 8'd1;
                        if (!arm_persist_q)
                            armed <= 1'b0;
                        idx   <= '0;
                        state <= S_FETCH_A;
                    end
                    S_FETCH_A: state <= S_FETCH_D;
                    S_FETCH_D: begin
                        gap_cnt               <= {1'b0, rd_gap} - CNT_ONE;
                        evgSequenceEventTDATA <= rd_code;
                        idx                   <= idx + IDX_ONE;
                        state                 <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (gap_cnt[GW]) begin
                            evgSequenceEventTVALID <= 1'b1;
                            state                  <= S_EMIT;
                        end else begin
                            gap_cnt <= gap_cnt - CNT_ONE;
                        end
                    end
                    S_EMIT: if (accept) begin
                        evgSequenceEventTDATA <= rd_code;
                        idx                   <= idx + IDX_ONE;
                        if (rd_gap != '0) begin
                            evgSequenceEventTVALID <= 1'b0;
                            gap_cnt                <= {1'b0, rd_gap} - CNT_ONE;
                            state                  <= S_WAIT;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
            // A fresh arm outranks both abort and a non-persistent start
            if (armStrobe) begin
                armed         <= 1'b1;
                arm_bank_q    <= armBank;
                arm_repeat_q  <= armRepeat;
                arm_persist_q <= armPersistent;
            end
        end
    end
endmodule

// File: doc/evg_sequencer_multibank.md
Name: evg_sequencer_multibank

Overview:
Multi-bank event sequencer for the EVG transmitter. It replays stored (gap, event code) tables out of a parametrised number of RAM banks onto the evgTxClk event-request stream. Compared with the two-bank sequencer, it adds TREADY backpressure, per-run repeat counts, persistent arming, abort, and saturating statistics. Everything, including host table writes, runs in the evgTxClk domain; the host side reaches it through the existing forwarding/CSR logic.

Parameters:
SEQUENCE_RAM_CAPACITY, 1024, entries per bank (power of 2).
BANK_COUNT, 4, number of independent tables (power of 2, ≥2).
EVENTCODE_WIDTH, 8, event code width.
SEQUENCE_GAP_WIDTH, 24, gap field width in clocks.
REPEAT_WIDTH, 8, width of the run repeat count.
END_OF_TABLE_EVENT_CODE, 8'h7F, code that terminates a pass; never emitted.

Ports:
evgTxClk  in  1  transmitter clock; the only clock.
evgTxRst_n  in  1  asynchronous active-low reset.
wrEnable  in  1  single-cycle table write strobe.
wrAddress  in  log2(BANK_COUNT*SEQUENCE_RAM_CAPACITY)  write address as {bank, entry}.
wrData  in  SEQUENCE_GAP_WIDTH+EVENTCODE_WIDTH  write data as {gap, event}.
armStrobe  in  1  latch armBank/armRepeat/armPersistent.
armBank  in  log2(BANK_COUNT)  bank to run on the next start.
armRepeat  in  REPEAT_WIDTH  extra passes; all-ones means loop until abort.
armPersistent  in  1  1 = arm survives a start.
abortStrobe  in  1  stop the active run and clear the arm.
evgSequenceStart  in  1  single-cycle start request.
evgSequenceEventTDATA  out  EVENTCODE_WIDTH  event code.
evgSequenceEventTVALID  out  1  event valid.
evgSequenceEventTREADY  in  1  downstream accept.
sequenceActive  out  1  run in progress.
activeBank  out  log2(BANK_COUNT)  bank of the current or last run.
armed  out  1  arm pending.
passesRemaining  out  REPEAT_WIDTH  passes left after the current one.
startRequestsAccepted  out  8  count of accepted starts; wraps.
startRequestsIgnored  out  8  count of ignored starts; saturates at 255.

Behaviour:
- Reset (async, evgTxRst_n low):
  - TVALID, TDATA, sequenceActive, activeBank, armed, passesRemaining and both counters all go to 0.
  - FSM goes to IDLE.
  - RAM contents are not reset.
  - Reset asserted mid-run drops TVALID immediately, with no completion.
- RAM:
  - One write port and one read port.
  - Read latency is 1 clock (registered).
  - Writes to the bank being played are allowed and unprotected; the playback of that run is then undefined but must not hang.
- Arming:
  - armStrobe sets armed=1 and latches bank, repeat and persistent.
  - armStrobe is legal while active; it applies to the next start.
- Start (IDLE, evgSequenceStart=1, armed=1):
  - Set activeBank=armBank, passesRemaining=armRepeat, sequenceActive=1.
  - Increment startRequestsAccepted.
  - Clear armed unless persistent.
  - Go to FETCH.
- Ignored starts: a start seen while active, or while unarmed in IDLE, increments startRequestsIgnored (saturating at 255) and has no other effect.
- FSM states: IDLE → FETCH (2 clk: address, data) → WAIT (gap countdown) → EMIT (TVALID held) → WAIT or FETCH/IDLE.
- Timing:
  - With the start accepted at cycle T, entry 0 asserts TVALID at T+3+gap0.
  - Entry i>0 asserts TVALID gap_i+1 cycles after the acceptance cycle of entry i-1.
  - gap=0 with TREADY=1 gives back-to-back events on consecutive cycles; the next entry is prefetched during WAIT/EMIT to make this possible.
- Backpressure:
  - TVALID and TDATA are held stable until TREADY=1.
  - The next gap countdown starts only after acceptance, so stalls delay all later events and no events are dropped.
- End of pass: reached when the fetched event is END_OF_TABLE_EVENT_CODE, or when the entry index wraps past SEQUENCE_RAM_CAPACITY-1.
  - The END entry's gap is ignored.
  - If passesRemaining=0, return to IDLE, sequenceActive=0, TVALID=0.
  - If passesRemaining is all-ones, restart entry 0 with no decrement.
  - Otherwise decrement passesRemaining and restart entry 0.
  - On restart, entry 0 is timed as at start, measured from the end-detect cycle.
- Abort:
  - Next cycle: TVALID=0, IDLE, sequenceActive=0, armed=0.
  - An event being held but not yet accepted is discarded.
  - If abort and start occur in the same cycle, abort wins and the start counts as ignored.
  - If abort and armStrobe occur in the same cycle, the arm wins (armed=1 afterwards).
- Widths:
  - The gap counter is SEQUENCE_GAP_WIDTH+1 bits, with the MSB used as the done flag.
  - The entry index is log2(SEQUENCE_RAM_CAPACITY)+1 bits, with the MSB used as the wrap flag.

Test Plan:
- Reset release; bank 2 = {(5,0x10),(0,0x11),(0,0x7F)}; arm bank 2, repeat 0; start at cycle T with TREADY=1 → 0x10 at T+8, 0x11 at T+9; sequenceActive=0 by T+11; accepted=1; 0x7F never appears.
- Same table with TREADY low for 4 cycles from the first TVALID → 0x10 held stable for 4 cycles, 0x11 exactly 1 cycle after acceptance, event order unchanged.
- Arm repeat=2, non-persistent → event pattern appears 3 times, passesRemaining reads 2,1,0 across passes, armed=0 after start; a second start while IDLE → ignored=1.
- Arm repeat=all-ones, persistent; abort after 3 passes → TVALID=0 and IDLE the next cycle, armed=0; 300 starts while active → ignored saturates at 255.
- Fill bank 0 completely with no END code → run stops after entry 1023 (index wrap) and returns to IDLE.
- Assert evgTxRst_n low while TVALID=1 and TREADY=0 → all outputs 0 asynchronously; after release the module stays IDLE and a start is ignored because armed=0.
